// File: rtl/disp_scan_4dig.sv
// disp_scan_4dig: four-digit multiplexed 7-segment scan driver.
// Latches a packed 4-digit BCD value and scans it onto one shared active-low
// segment bus with four active-low anode selects. Each digit slot starts with
// one dark cycle to avoid ghosting. Leading zeros can be suppressed, and
// selected digits can blink at a frame-derived rate.
module disp_scan_4dig #(
    parameter int REFRESH_N = 50000,   // clk cycles per digit slot (>= 2)
    parameter int BLINK_DIV = 250      // frames per blink half-period (>= 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        blank_lz,
    input  logic [3:0]  blink_mask,
    output logic [0:6]  seg_out,
    output logic [3:0]  an_out,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    // Counter widths; BLINK_DIV = 1 still needs a 1-bit frame counter.
    localparam int PRESC_W = (REFRESH_N > 1) ? $clog2(REFRESH_N) : 1;
    localparam int FC_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_N - 1);
    localparam logic [FC_W-1:0]    FC_MAX    = FC_W'(BLINK_DIV - 1);

    localparam logic [0:6] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low glyphs, bit order a..g; non-BCD nibbles show a dash.
    function automatic logic [0:6] glyph(input logic [3:0] nib);
        logic [0:6] g;
        case (nib)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            default: g = 7'b1111110;
        endcase
        return g;
    endfunction

    // Registered state
    logic [15:0]        value_q, value_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [1:0]         idx_q, idx_d;
    logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [0:6]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic               frame_done_q, frame_done_d;

    // Per-digit decode helpers
    logic [0:6] glyph_w [4];
    logic [3:0] upper_zero;    // nibbles gi..3 are all zero
    logic [3:0] lz_blank;      // digit suppressed as a leading zero
    logic [3:0] digit_blank;   // digit dark for its whole slot

    logic presc_wrap;
    logic frame_wrap;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign glyph_w[gi]    = glyph(value_q[4*gi +: 4]);
            assign upper_zero[gi] = (value_q[15:4*gi] == '0);
            if (gi == 0) begin : g_rightmost
                // The rightmost digit always shows, so a zero value reads "0".
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = blank_lz & upper_zero[gi];
            end
            assign digit_blank[gi] = lz_blank[gi] | (blink_phase_q & blink_mask[gi]);
        end
    endgenerate

    // Slot/frame timing: prescaler wrap advances the digit index; the
    // 3->0 advance ends a frame and drives the blink frame counter.
    always_comb begin
        presc_wrap    = (presc_q == PRESC_MAX);
        frame_wrap    = presc_wrap && (idx_q == 2'd3);

        presc_d       = presc_wrap ? '0 : presc_q + PRESC_W'(1);
        idx_d         = presc_wrap ? idx_q + 2'd1 : idx_q;
        frame_done_d  = frame_wrap;

        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_wrap) begin
            if (frame_cnt_q == FC_MAX) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d   = frame_cnt_q + FC_W'(1);
            end
        end

        value_d = load ? value_in : value_q;
    end

    // Output decode of the current cycle's state; registered one cycle later.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        // First cycle of each slot stays dark so the previous glyph never
        // bleeds onto the newly selected anode.
        if ((presc_q != '0) && !digit_blank[idx_q]) begin
            an_d        = AN_OFF;
            an_d[idx_q] = 1'b0;
            seg_d       = glyph_w[idx_q];
        end
    end

    // State and output registers; reset overrides load and all counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q       <= '0;
            presc_q       <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            value_q       <= value_d;
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign digit_sel  = idx_q;
    assign frame_done = frame_done_q;

endmodule
